// File: rtl/p_alu.sv
// Shared ALU definitions: datapath width and unary operation encodings.
package p_alu;

    localparam int unsigned ALU_DATA_W = 32;
    localparam int unsigned UNARY_OP_W = 2;

    typedef enum logic [UNARY_OP_W-1:0] {
        OpId   = 2'd0,
        OpNot  = 2'd1,
        OpNeg  = 2'd2,
        OpZero = 2'd3
    } e_unary_op;

endpackage

// File: rtl/m_alu_unary.sv
// Combinational single-operand ALU: identity, bitwise NOT, two's-complement negate, zero.
module m_alu_unary
    import p_alu::*;
(
    input  logic [ALU_DATA_W-1:0] operand,
    input  e_unary_op             op,
    output logic [ALU_DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OpId:    result = operand;
            OpNot:   result = ~operand;
            OpNeg:   result = -operand;
            OpZero:  result = '0;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/m_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping mod N.
module m_rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_idx
);

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= int'(N)) begin
            s = s - int'(N);
        end
        return ID_W'(s);
    endfunction

    // Walk the offsets from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (req[wrap_idx(ptr, k)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_idx(ptr, k);
            end
        end
    end

endmodule

// File: rtl/m_alu_unary_arb.sv
// Shares one unary ALU among N_REQ requesters; round-robin grant, one-entry tagged response buffer.
module m_alu_unary_arb
    import p_alu::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned ID_W = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*ALU_DATA_W-1:0] req_in,
    input  logic [N_REQ*UNARY_OP_W-1:0] req_op,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [ALU_DATA_W-1:0]       resp_out,
    output logic [ID_W-1:0]             resp_id
);

    logic                  resp_valid_q, resp_valid_d;
    logic [ALU_DATA_W-1:0] resp_out_q, resp_out_d;
    logic [ID_W-1:0]       resp_id_q, resp_id_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic                  grant_valid;
    logic [ID_W-1:0]       grant_idx;
    logic                  can_accept;
    logic                  transfer;
    logic [ALU_DATA_W-1:0] sel_in;
    logic [UNARY_OP_W-1:0] sel_op;
    logic [ALU_DATA_W-1:0] alu_result;
    logic [ID_W-1:0]       next_ptr;

    m_rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req         (req_valid),
        .ptr         (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        sel_in = '0;
        sel_op = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_in = req_in[i*ALU_DATA_W +: ALU_DATA_W];
                sel_op = req_op[i*UNARY_OP_W +: UNARY_OP_W];
            end
        end
    end

    m_alu_unary u_alu (
        .operand (sel_in),
        .op      (e_unary_op'(sel_op)),
        .result  (alu_result)
    );

    // rst_n gates the handshake so no requester sees ready while the buffer is held in reset.
    assign can_accept = !resp_valid_q || resp_ready;
    assign transfer   = rst_n && can_accept && grant_valid;
    assign next_ptr   = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_out_d   = resp_out_q;
        resp_id_d    = resp_id_q;
        rr_ptr_d     = rr_ptr_q;
        if (transfer) begin
            resp_valid_d = 1'b1;
            resp_out_d   = alu_result;
            resp_id_d    = grant_idx;
            rr_ptr_d     = next_ptr;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_out_q   <= '0;
            resp_id_q    <= '0;
            rr_ptr_q     <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_out_q   <= resp_out_d;
            resp_id_q    <= resp_id_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_out   = resp_out_q;
    assign resp_id    = resp_id_q;

endmodule

// File: doc/m_alu_unary_arb.md
Name: m_alu_unary_arb

Overview:
- Shares one m_alu_unary instance among N_REQ requesters using per-requester valid/ready handshakes.
- Round-robin arbiter picks one pending request per cycle and drives it through the combinational unary unit.
- Result is captured in a one-entry registered response buffer, tagged with the winning requester's index.
- Sits between issue logic (multiple lanes or a microcode sequencer) and the writeback path.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(N_REQ), width of the requester tag; derived, never overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  request pending, one bit per requester.
- req_ready  out  N_REQ  request accepted this cycle, one bit per requester.
- req_in  in  N_REQ*32  operands, packed; requester i occupies bits [32*i+31:32*i].
- req_op  in  N_REQ*2  e_unary_op per requester, packed the same way.
- resp_valid  out  1  response buffer holds a result.
- resp_ready  in  1  downstream accepts the response.
- resp_out  out  32  registered m_alu_unary result.
- resp_id  out  ID_W  index of the requester that produced resp_out.

Behaviour:
- Reset, asynchronous on rst_n low:
  - resp_valid=0, resp_out=0, resp_id=0, rr_ptr=0.
  - req_ready is combinationally 0 while in reset.
- can_accept = !resp_valid || resp_ready.
- Arbitration (combinational):
  - Scan indices rr_ptr, rr_ptr+1, … mod N_REQ.
  - The first i with req_valid[i]=1 is the grant g.
  - No valid request means no grant.
- Readiness:
  - req_ready[i] = can_accept && (i==g) && grant exists.
  - At most one req_ready bit is high per cycle.
  - req_ready may depend on req_valid.
- Transfer occurs when req_valid[g] && req_ready[g]. On the next clk edge:
  - resp_out <= unary(req_in[g], req_op[g]).
  - resp_id <= g.
  - resp_valid <= 1.
  - rr_ptr <= (g+1) mod N_REQ.
- Latency: exactly 1 cycle from request handshake to resp_valid.
- Throughput: 1 result/cycle while resp_ready is held high.
- Drain without refill: if resp_valid && resp_ready and there is no transfer, resp_valid <= 0. resp_out and resp_id hold their last values.
- Simultaneous drain and refill: when resp_ready and a new transfer occur in the same cycle, the buffer reloads and resp_valid stays 1 with no bubble.
- Backpressure: while resp_valid && !resp_ready:
  - resp_out and resp_id are stable.
  - All req_ready are 0.
  - rr_ptr is unchanged.
- rr_ptr advances only on a transfer, never on idle cycles.
- Fairness: a requester holding req_valid is granted within N_REQ transfers.
- Requester obligation: once req_valid[i] is raised it must hold, with req_in/req_op stable, until req_ready[i]. The arbiter does not check this.
- Reset mid-operation: a buffered, unconsumed result is discarded and the pointer returns to 0.
- Op encodings outside e_unary_op are not produced by requesters. Behaviour for them follows m_alu_unary.
- Arithmetic: 32-bit, wrap-around per m_alu_unary; NEG is two's complement, so NEG(32'h80000000)=32'h80000000.

Decomposition:
- p_alu (existing) supplies e_unary_op. Add:
  - UNARY_OP_W = 2, the width of e_unary_op.
  - ALU_DATA_W = 32.
- Sub-module m_rr_arbiter #(N) with ports: req[N], ptr[ID_W] → grant_valid, grant_idx[ID_W]. It is purely combinational and reusable by the future binary-op arbiter.
- m_alu_unary is instantiated once, driven by the mux of req_in/req_op at grant_idx.
- m_alu_unary_arb holds rr_ptr, the response buffer and the handshake logic.

Test Plan:
- Reset and single request:
  - Hold rst_n=0: check resp_valid=0, resp_out=0 and req_ready=0.
  - Release reset, then req0 {in=32'h1, op=NEG}.
  - Expect req_ready[0] in the same cycle, then next cycle resp_valid=1, resp_out=32'hffffffff, resp_id=0.
- Round-robin order:
  - All 4 valid with op=NOT, in=i, resp_ready=1.
  - Expect resp_id sequence 0,1,2,3,0, and resp_out for id 2 = 32'hfffffffd.
- Backpressure:
  - Hold resp_ready=0 with req1 {in=32'h55555555, op=NOT} and req2 pending.
  - Expect resp_out=32'haaaaaaaa/id=1 held stable 5 cycles, req_ready all 0.
  - Raise resp_ready: next cycle shows id=2.
- Back-to-back drain and refill:
  - resp_ready=1 with req3 continuously valid {in=32'hffffffff, op=ID}.
  - Expect resp_valid high every cycle, resp_out=32'hffffffff, no bubble.
- Pointer skip:
  - Only req2 valid (rr_ptr=0): granted immediately, rr_ptr→3.
  - Then req0 and req2 valid: req0 is granted first.
- Reset mid-operation:
  - With resp_valid=1 holding ZERO result id=3, pulse rst_n low asynchronously, between clock edges.
  - Expect resp_valid=0 immediately.
  - After release, only req1 valid: granted with resp_id=1.
